// File: rtl/fifo_mux_buf_if.sv
// fifo_mux_buf_if: handshake/data bundle between the 2:1 mux stage, the
// FIFO buffer and the downstream consumer.
//   data_in/valid_in : byte and push strobe from the mux (no backpressure)
//   pop              : read request from the downstream stage
//   data_out/valid_out: registered read data, valid for one cycle per pop
//   full/empty/almost_full/almost_empty : occupancy flags
//   overflow         : sticky "a pushed byte was dropped"
interface fifo_mux_buf_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;

    // master: the producer/consumer side driving pushes and pops
    modport master (
        output data_in, valid_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, overflow
    );

    // slave: the FIFO itself
    modport slave (
        input  data_in, valid_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty, overflow
    );
endinterface

// File: rtl/fifo_mux_buf.sv
// fifo_mux_buf: synchronous FIFO behind the 2:1 mux. Captures every valid
// byte from the mux, holds it until popped, reports occupancy and flags a
// sticky overflow when a byte arrives with no room.
// Ports:
//   clk     : block clock, all flops on posedge
//   reset_L : asynchronous active-low reset
//   bus     : fifo_mux_buf_if.slave (push/pop handshake, data, flags)
module fifo_mux_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_TH      = 3,
    parameter int AE_TH      = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    fifo_mux_buf_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [ADDR_WIDTH-1:0]            wr_ptr;
    logic [ADDR_WIDTH-1:0]            rd_ptr;
    logic [CNT_W-1:0]                 count;
    logic [DATA_WIDTH-1:0]            data_q;
    logic                             vld_q;
    logic                             ovf_q;

    logic full_w;
    logic empty_w;
    logic pop_ok;
    logic push_ok;

    assign full_w  = (count == DEPTH_C);
    assign empty_w = (count == '0);
    assign pop_ok  = bus.pop && !empty_w;
    // When full, a same-cycle pop frees the slot being written: wr_ptr equals
    // rd_ptr, and the read uses the pre-edge contents, so both are safe.
    assign push_ok = bus.valid_in && (!full_w || pop_ok);

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_q <= mem[rd_ptr];
            end
            vld_q <= pop_ok;
            if (bus.valid_in && !push_ok) ovf_q <= 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.data_out     = data_q;
    assign bus.valid_out    = vld_q;
    assign bus.overflow     = ovf_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count >= AF_C);
    assign bus.almost_empty = (count <= AE_C);
endmodule

// File: tb/tb_fifo_mux_buf.sv
// tb_fifo_mux_buf: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based model of the FIFO.
module tb_fifo_mux_buf;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF_TH = 3;
    localparam int AE_TH = 1;

    logic clk;
    logic reset_L;

    fifo_mux_buf_if #(.DATA_WIDTH(DW)) bus ();

    fifo_mux_buf #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(2), .AF_TH(AF_TH), .AE_TH(AE_TH)
    ) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {data_out, valid_out, full, empty, almost_full, almost_empty, overflow}
    function automatic logic [13:0] pack_out();
        return {bus.data_out, bus.valid_out, bus.full, bus.empty,
                bus.almost_full, bus.almost_empty, bus.overflow};
    endfunction

    task automatic cmp(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got dout=%h v=%b f=%b e=%b af=%b ae=%b ovf=%b want dout=%h v=%b f=%b e=%b af=%b ae=%b ovf=%b",
                     name, act[13:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[13:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_vout;
    logic          m_ovf;

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_vout = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic vin, input logic [DW-1:0] din, input logic p);
        int  sz;
        bit  pok;
        bit  push;
        sz   = mq.size();
        pok  = p && (sz > 0);
        push = vin && ((sz < DEPTH) || pok);
        if (pok) begin
            m_dout = mq.pop_front();
            m_vout = 1'b1;
        end else begin
            m_vout = 1'b0;
        end
        if (push) mq.push_back(din);
        else if (vin) m_ovf = 1'b1;
    endtask

    function automatic logic [13:0] model_out();
        int sz;
        sz = mq.size();
        return {m_dout, m_vout, sz == DEPTH, sz == 0, sz >= AF_TH, sz <= AE_TH, m_ovf};
    endfunction

    // drive at negedge, clock, sample 1 time unit after the posedge
    task automatic drive(input logic vin, input logic [DW-1:0] din, input logic p);
        @(negedge clk);
        bus.valid_in = vin;
        bus.data_in  = din;
        bus.pop      = p;
        @(posedge clk);
        #1;
    endtask

    task automatic mstep(input string name, input logic vin, input logic [DW-1:0] din, input logic p);
        drive(vin, din, p);
        model_edge(vin, din, p);
        cmp(name, pack_out(), model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.pop      = 1'b0;
        reset_L      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic          vin;
        logic [DW-1:0] din;
        logic          pop;
        logic [13:0]   exp;   // packed like pack_out()
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic vin, input logic [7:0] din,
                                input logic p, input logic [7:0] d, input logic v,
                                input logic f, input logic e, input logic af,
                                input logic ae, input logic o);
        vec_t r;
        r.rst = rst; r.vin = vin; r.din = din; r.pop = p;
        r.exp = {d, v, f, e, af, ae, o};
        return r;
    endfunction

    logic [DW-1:0] wexp[$];
    logic [DW-1:0] w;

    initial begin
        reset_L      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.pop      = 1'b0;
        model_reset();

        //            rst vin din    pop  dout  v f e af ae ovf
        vt.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0,0,1,0,1,0)); // idle after reset
        vt.push_back(mk(0, 1, 8'hA1, 0, 8'h00, 0,0,0,0,1,0));
        vt.push_back(mk(0, 1, 8'hB2, 0, 8'h00, 0,0,0,0,0,0));
        vt.push_back(mk(0, 1, 8'hC3, 0, 8'h00, 0,0,0,1,0,0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hA1, 1,0,0,0,0,0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hB2, 1,0,0,0,1,0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hC3, 1,0,1,0,1,0));
        vt.push_back(mk(0, 0, 8'h00, 0, 8'hC3, 0,0,1,0,1,0));
        vt.push_back(mk(0, 1, 8'h11, 0, 8'hC3, 0,0,0,0,1,0));
        vt.push_back(mk(0, 1, 8'h22, 0, 8'hC3, 0,0,0,0,0,0));
        vt.push_back(mk(0, 1, 8'h33, 0, 8'hC3, 0,0,0,1,0,0));
        vt.push_back(mk(0, 1, 8'h44, 0, 8'hC3, 0,1,0,1,0,0));
        vt.push_back(mk(0, 1, 8'h55, 0, 8'hC3, 0,1,0,1,0,1)); // dropped
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h11, 1,0,0,1,0,1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h22, 1,0,0,0,0,1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h33, 1,0,0,0,1,1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h44, 1,0,1,0,1,1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h44, 0,0,1,0,1,1)); // pop on empty
        vt.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0,0,1,0,1,0)); // reset clears ovf
        vt.push_back(mk(0, 1, 8'h01, 0, 8'h00, 0,0,0,0,1,0));
        vt.push_back(mk(0, 1, 8'h02, 0, 8'h00, 0,0,0,0,0,0));
        vt.push_back(mk(0, 1, 8'h03, 0, 8'h00, 0,0,0,1,0,0));
        vt.push_back(mk(0, 1, 8'h04, 0, 8'h00, 0,1,0,1,0,0));
        vt.push_back(mk(0, 1, 8'h66, 1, 8'h01, 1,1,0,1,0,0)); // full push+pop
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h02, 1,0,0,1,0,0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h03, 1,0,0,0,0,0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h04, 1,0,0,0,1,0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h66, 1,0,1,0,1,0));
        vt.push_back(mk(0, 1, 8'h7E, 1, 8'h66, 0,0,0,0,1,0)); // no fall-through
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h7E, 1,0,1,0,1,0));

        // reset state before any clock edge
        #3;
        cmp("reset_async", pack_out(), {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        reset_L = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            reset_L      = !vt[i].rst;
            bus.valid_in = vt[i].vin;
            bus.data_in  = vt[i].din;
            bus.pop      = vt[i].pop;
            @(posedge clk);
            #1;
            cmp($sformatf("vec%0d", i), pack_out(), vt[i].exp);
            if (vt[i].rst) begin
                @(negedge clk);
                reset_L = 1'b1;
            end
        end

        // wrap-around: hold count at 2 with 10 cycles of push+pop
        do_reset();
        mstep("wrap_fill0", 1'b1, 8'h90, 1'b0);
        mstep("wrap_fill1", 1'b1, 8'h91, 1'b0);
        wexp.push_back(8'h90);
        wexp.push_back(8'h91);
        for (int k = 0; k < 10; k++) begin
            w = 8'hA0 + 8'(k);
            wexp.push_back(w);
            mstep($sformatf("wrap%0d", k), 1'b1, w, 1'b1);
            cmp($sformatf("wrap_data%0d", k), pack_out(),
                {wexp.pop_front(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end

        // asynchronous reset between edges with 2 words stored
        mstep("pre_rst_pop", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #2;
        reset_L = 1'b0;
        #1;
        cmp("rst_midcycle", pack_out(), {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
        mstep("pop_after_rst", 1'b0, 8'h00, 1'b1);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            mstep($sformatf("rand%0d", k), 1'($urandom_range(0, 99) < 60),
                  8'($urandom), 1'($urandom_range(0, 99) < 45));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
